// File: rtl/sram_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// sram_pkg : shared SRAM bus constants, loader state type, channel indices
// Revision 1.0
// ----------------------------------------------------------------------
package sram_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int DATA_W      = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PIX  = 3'd1,
    WR_SETUP  = 3'd2,
    WR_STROBE = 3'd3,
    DONE      = 3'd4
  } load_state_t;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sram_write_port.sv
`default_nettype none
// ----------------------------------------------------------------------
// sram_write_port : one SRAM write as SETUP (WE_N high) then STROBE (WE_N low)
// Revision 1.0
// ----------------------------------------------------------------------
module sram_write_port
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_addr,
  output wire  [DATA_W-1:0] o_data,
  output logic              o_we_n,
  output logic              o_wr_done
);

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_active;
  logic              r_strobe;

  // A request captures address and data so both stay fixed across SETUP and STROBE.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr   <= '0;
      r_data   <= '0;
      r_active <= 1'b0;
      r_strobe <= 1'b0;
    end else if (i_req) begin
      r_addr   <= i_addr;
      r_data   <= i_data;
      r_active <= 1'b1;
      r_strobe <= 1'b0;
    end else if (r_active && !r_strobe) begin
      r_strobe <= 1'b1;
    end else begin
      r_active <= 1'b0;
      r_strobe <= 1'b0;
    end
  end

  assign o_addr    = r_addr;
  assign o_data    = r_active ? r_data : {DATA_W{1'bz}};
  assign o_we_n    = ~r_strobe;
  assign o_wr_done = r_strobe;

endmodule
`default_nettype wire

// File: rtl/sram_pixel_loader.sv
`default_nettype none
// ----------------------------------------------------------------------
// sram_pixel_loader : writes a two-photo RGB stream into planar SRAM layout
// Revision 1.0
// ----------------------------------------------------------------------
module sram_pixel_loader
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DIM_W  = 10
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              start_load,
  input  logic [DIM_W-1:0]  iCol_Max,
  input  logic [DIM_W-1:0]  iRow_Max,
  input  logic              iPixel_valid,
  input  logic [7:0]        iPixel_R,
  input  logic [7:0]        iPixel_G,
  input  logic [7:0]        iPixel_B,
  output logic              oPixel_ready,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  output wire  [DATA_W-1:0] oSRAM_DATA,
  output logic              oSRAM_WE_N,
  output logic              oSRAM_OE_N,
  output logic              oLoad_done
);

  localparam logic [ADDR_W-1:0] C_ONE = ADDR_W'(1);

  load_state_t       r_state, w_next;
  logic [ADDR_W-1:0] r_n, r_p, r_base, r_photo_base;
  logic [1:0]        r_c;
  logic              r_f;
  logic [7:0]        r_g, r_b;

  logic [2*DIM_W-1:0] w_prod;
  logic [ADDR_W-1:0]  w_n;
  logic               w_last_pix;
  logic               w_req, w_wr_done;
  logic [ADDR_W-1:0]  w_req_addr;
  logic [DATA_W-1:0]  w_req_data;

  assign w_prod     = {{DIM_W{1'b0}}, iCol_Max} * {{DIM_W{1'b0}}, iRow_Max};
  assign w_n        = ADDR_W'(w_prod);
  assign w_last_pix = (r_p == r_n - C_ONE);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_req        = 1'b0;
    w_req_addr   = r_base + r_p;
    w_req_data   = {8'h00, iPixel_R};
    oPixel_ready = 1'b0;
    oLoad_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_load) w_next = (w_n == '0) ? DONE : WAIT_PIX;
      end
      WAIT_PIX: begin
        oPixel_ready = 1'b1;
        if (iPixel_valid) begin
          w_req  = 1'b1;
          w_next = WR_SETUP;
        end
      end
      WR_SETUP: w_next = WR_STROBE;
      WR_STROBE: begin
        if (w_wr_done) begin
          if (r_c != CH_B) begin
            // Next channel plane sits exactly N words above the current one.
            w_req      = 1'b1;
            w_req_addr = r_base + r_n + r_p;
            w_req_data = {8'h00, (r_c == CH_R) ? r_g : r_b};
            w_next     = WR_SETUP;
          end else if (r_f && w_last_pix) begin
            w_next = DONE;
          end else begin
            w_next = WAIT_PIX;
          end
        end
      end
      DONE: begin
        oLoad_done = 1'b1;
        if (!start_load) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_n          <= '0;
      r_p          <= '0;
      r_c          <= CH_R;
      r_f          <= 1'b0;
      r_base       <= '0;
      r_photo_base <= '0;
      r_g          <= '0;
      r_b          <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_load) begin
            r_n          <= w_n;
            r_p          <= '0;
            r_c          <= CH_R;
            r_f          <= 1'b0;
            r_base       <= '0;
            r_photo_base <= '0;
          end
        end
        WAIT_PIX: begin
          if (iPixel_valid) begin
            r_g <= iPixel_G;
            r_b <= iPixel_B;
            r_c <= CH_R;
          end
        end
        WR_STROBE: begin
          if (w_wr_done) begin
            if (r_c != CH_B) begin
              r_c    <= r_c + 2'd1;
              r_base <= r_base + r_n;
            end else begin
              r_c <= CH_R;
              // Wrapping into photo 1 moves the photo base past the three source planes.
              if (w_last_pix) begin
                r_p          <= '0;
                r_f          <= 1'b1;
                r_base       <= r_base + r_n;
                r_photo_base <= r_base + r_n;
              end else begin
                r_p    <= r_p + C_ONE;
                r_base <= r_photo_base;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  sram_write_port #(
    .ADDR_W (ADDR_W)
  ) u_write_port (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_req     (w_req),
    .i_addr    (w_req_addr),
    .i_data    (w_req_data),
    .o_addr    (oSRAM_ADDR),
    .o_data    (oSRAM_DATA),
    .o_we_n    (oSRAM_WE_N),
    .o_wr_done (w_wr_done)
  );

  assign oSRAM_OE_N = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_sram_pixel_loader.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_sram_pixel_loader : randomized load scenarios against a planar-layout model
// Revision 1.0
// ----------------------------------------------------------------------
module tb_sram_pixel_loader;

  localparam int AW = 20;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          start_load = 1'b0;
  logic [DW-1:0] iCol_Max = '0;
  logic [DW-1:0] iRow_Max = '0;
  logic          iPixel_valid = 1'b0;
  logic [7:0]    iPixel_R = '0, iPixel_G = '0, iPixel_B = '0;
  logic          oPixel_ready;
  logic [AW-1:0] oSRAM_ADDR;
  wire  [15:0]   sram_dq;
  logic          oSRAM_WE_N, oSRAM_OE_N, oLoad_done;

  // A released bus floats up to all ones, which no real data word {8'h00, x} can equal.
  pullup (sram_dq);

  sram_pixel_loader #(.ADDR_W(AW), .DIM_W(DW)) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .start_load   (start_load),
    .iCol_Max     (iCol_Max),
    .iRow_Max     (iRow_Max),
    .iPixel_valid (iPixel_valid),
    .iPixel_R     (iPixel_R),
    .iPixel_G     (iPixel_G),
    .iPixel_B     (iPixel_B),
    .oPixel_ready (oPixel_ready),
    .oSRAM_ADDR   (oSRAM_ADDR),
    .oSRAM_DATA   (sram_dq),
    .oSRAM_WE_N   (oSRAM_WE_N),
    .oSRAM_OE_N   (oSRAM_OE_N),
    .oLoad_done   (oLoad_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Bus observer: records every write and protocol events, sampled mid-cycle.
  int            cycle_cnt = 0;
  int            hs_cnt = 0, stab_viol = 0, rdy_viol = 0, done_rise = 0;
  int            last_hs_cyc = 0, done_cyc = 0;
  logic [AW-1:0] wr_addr_q[$];
  logic [15:0]   wr_data_q[$];
  logic [AW-1:0] prev_addr = '0;
  logic [15:0]   prev_data = '0;
  logic          prev_we_n = 1'b1, prev_done = 1'b0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  always @(negedge clk) begin
    if (!i_rst) begin
      if (oPixel_ready && iPixel_valid) begin
        hs_cnt      <= hs_cnt + 1;
        last_hs_cyc <= cycle_cnt;
      end
      if (oPixel_ready && (!oSRAM_WE_N || sram_dq !== 16'hFFFF)) rdy_viol <= rdy_viol + 1;
      if (!oSRAM_WE_N) begin
        if (!prev_we_n || oSRAM_ADDR !== prev_addr || sram_dq !== prev_data)
          stab_viol <= stab_viol + 1;
        wr_addr_q.push_back(oSRAM_ADDR);
        wr_data_q.push_back(sram_dq);
      end
      if (oLoad_done && !prev_done) begin
        done_rise <= done_rise + 1;
        done_cyc  <= cycle_cnt;
      end
    end
    prev_addr <= oSRAM_ADDR;
    prev_data <= sram_dq;
    prev_we_n <= oSRAM_WE_N;
    prev_done <= oLoad_done;
  end

  logic [7:0] pr[256], pg[256], pb[256];
  int s_wr0, s_hs0, s_sv0, s_rv0, s_dn0;

  // Reference model: channel c of stream pixel k lands at (f*3+c)*N + p.
  function automatic logic [AW-1:0] model_addr(input int n, input int k, input int c);
    return AW'(((k / n) * 3 + c) * n + (k % n));
  endfunction

  function automatic logic [15:0] model_data(input int k, input int c);
    logic [7:0] v;
    v = (c == 0) ? pr[k] : (c == 1) ? pg[k] : pb[k];
    return {8'h00, v};
  endfunction

  task automatic do_load(input int cols, input int rows, input bit gapped, output bit to);
    int n, k, cyc;
    bit hs;
    n = cols * rows; k = 0; cyc = 0;
    s_wr0 = wr_addr_q.size(); s_hs0 = hs_cnt; s_sv0 = stab_viol; s_rv0 = rdy_viol; s_dn0 = done_rise;
    iCol_Max = DW'(cols); iRow_Max = DW'(rows); start_load = 1'b1;
    @(posedge clk); #1;
    start_load = 1'b0;
    while (k < 2 * n && cyc < 3000) begin
      if (gapped && $urandom_range(0, 2) == 0) begin
        iPixel_valid = 1'b0;
        iPixel_R = 8'($urandom); iPixel_G = 8'($urandom); iPixel_B = 8'($urandom);
      end else begin
        iPixel_valid = 1'b1;
        iPixel_R = pr[k]; iPixel_G = pg[k]; iPixel_B = pb[k];
      end
      hs = iPixel_valid && oPixel_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) k++;
    end
    iPixel_valid = 1'b0;
    while (done_rise == s_dn0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    to = (done_rise == s_dn0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (oPixel_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b, expected 0", oPixel_ready); end
    n_vec++; if (oSRAM_ADDR !== '0) begin n_err++; $display("FAIL reset_addr: got %0h, expected 0", oSRAM_ADDR); end
    n_vec++; if (sram_dq !== 16'hFFFF) begin n_err++; $display("FAIL reset_data_z: got %0h, expected released bus", sram_dq); end
    n_vec++; if (oSRAM_WE_N !== 1'b1) begin n_err++; $display("FAIL reset_we_n: got %b, expected 1", oSRAM_WE_N); end
    n_vec++; if (oSRAM_OE_N !== 1'b1) begin n_err++; $display("FAIL reset_oe_n: got %b, expected 1", oSRAM_OE_N); end
    n_vec++; if (oLoad_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b, expected 0", oLoad_done); end
    i_rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_held_5x5;
    bit to;
    int n, nw;
    n = 25;
    for (int k = 0; k < 2 * n; k++) begin pr[k] = 8'(k); pg[k] = 8'(k + 1); pb[k] = 8'(k + 2); end
    do_load(5, 5, 1'b0, to);
    nw = wr_addr_q.size() - s_wr0;
    n_vec++; if (to) begin n_err++; $display("FAIL held_timeout: done not seen, expected done"); end
    n_vec++; if (nw != 6 * n) begin n_err++; $display("FAIL held_write_count: got %0d, expected %0d", nw, 6 * n); end
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (nw < 3 || wr_addr_q[s_wr0 + c] !== AW'(25 * c) || wr_data_q[s_wr0 + c] !== 16'(c)) begin
        n_err++; $display("FAIL held_p0_ch%0d: got %0h/%0h, expected %0h/%0h", c,
                          wr_addr_q[s_wr0 + c], wr_data_q[s_wr0 + c], 25 * c, c);
      end
      n_vec++;
      if (nw < 78 || wr_addr_q[s_wr0 + 75 + c] !== AW'(75 + 25 * c)) begin
        n_err++; $display("FAIL held_photo1_ch%0d: got %0h, expected %0h", c, wr_addr_q[s_wr0 + 75 + c], 75 + 25 * c);
      end
    end
    n_vec++; if (nw != 150 || wr_addr_q[s_wr0 + 149] !== AW'(149)) begin n_err++; $display("FAIL held_last_addr: got %0h, expected 95", wr_addr_q[wr_addr_q.size() - 1]); end
    for (int k = 0; k < 2 * n; k++)
      for (int c = 0; c < 3; c++) begin
        n_vec++;
        if (s_wr0 + 3 * k + c >= wr_addr_q.size() || wr_addr_q[s_wr0 + 3 * k + c] !== model_addr(n, k, c) ||
            wr_data_q[s_wr0 + 3 * k + c] !== model_data(k, c)) begin
          n_err++; $display("FAIL held_write k=%0d c=%0d: got %0h/%0h, expected %0h/%0h", k, c,
                            wr_addr_q[s_wr0 + 3 * k + c], wr_data_q[s_wr0 + 3 * k + c], model_addr(n, k, c), model_data(k, c));
        end
      end
    n_vec++; if (hs_cnt - s_hs0 != 2 * n) begin n_err++; $display("FAIL held_pixel_count: got %0d, expected %0d", hs_cnt - s_hs0, 2 * n); end
    n_vec++; if (stab_viol != s_sv0) begin n_err++; $display("FAIL held_write_stability: got %0d, expected 0", stab_viol - s_sv0); end
    n_vec++; if (rdy_viol != s_rv0) begin n_err++; $display("FAIL held_ready_window: got %0d, expected 0", rdy_viol - s_rv0); end
    // Sample before the last handshake edge, then six cycles of channel writes.
    n_vec++; if (done_cyc - last_hs_cyc != 1 + 6) begin n_err++; $display("FAIL held_done_latency: got %0d, expected 7", done_cyc - last_hs_cyc); end
    n_vec++; if (sram_dq !== 16'hFFFF || oSRAM_WE_N !== 1'b1) begin n_err++; $display("FAIL held_bus_release: got %0h/%b, expected released/1", sram_dq, oSRAM_WE_N); end
  endtask

  task automatic test_gapped_5x5;
    bit to;
    int n;
    n = 25;
    do_load(5, 5, 1'b1, to);
    n_vec++; if (to) begin n_err++; $display("FAIL gapped_timeout: done not seen, expected done"); end
    n_vec++; if (wr_addr_q.size() - s_wr0 != 6 * n) begin n_err++; $display("FAIL gapped_write_count: got %0d, expected %0d", wr_addr_q.size() - s_wr0, 6 * n); end
    for (int k = 0; k < 2 * n; k++)
      for (int c = 0; c < 3; c++) begin
        n_vec++;
        if (s_wr0 + 3 * k + c >= wr_addr_q.size() || wr_addr_q[s_wr0 + 3 * k + c] !== model_addr(n, k, c) ||
            wr_data_q[s_wr0 + 3 * k + c] !== model_data(k, c)) begin
          n_err++; $display("FAIL gapped_write k=%0d c=%0d: got %0h/%0h, expected %0h/%0h", k, c,
                            wr_addr_q[s_wr0 + 3 * k + c], wr_data_q[s_wr0 + 3 * k + c], model_addr(n, k, c), model_data(k, c));
        end
      end
    n_vec++; if (hs_cnt - s_hs0 != 2 * n) begin n_err++; $display("FAIL gapped_pixel_count: got %0d, expected %0d", hs_cnt - s_hs0, 2 * n); end
    n_vec++; if (rdy_viol != s_rv0) begin n_err++; $display("FAIL gapped_ready_window: got %0d, expected 0", rdy_viol - s_rv0); end
    n_vec++; if (stab_viol != s_sv0) begin n_err++; $display("FAIL gapped_write_stability: got %0d, expected 0", stab_viol - s_sv0); end
  endtask

  task automatic test_photo_boundary;
    bit to;
    int n;
    n = 6;
    for (int k = 0; k < 2 * n; k++) begin pr[k] = 8'($urandom); pg[k] = 8'($urandom); pb[k] = 8'($urandom); end
    do_load(3, 2, 1'b1, to);
    n_vec++; if (to) begin n_err++; $display("FAIL boundary_timeout: done not seen, expected done"); end
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (s_wr0 + 18 + c >= wr_addr_q.size() || wr_addr_q[s_wr0 + 18 + c] !== AW'(18 + 6 * c)) begin
        n_err++; $display("FAIL boundary_pix7_ch%0d: got %0h, expected %0h", c, wr_addr_q[s_wr0 + 18 + c], 18 + 6 * c);
      end
    end
    for (int k = 0; k < 2 * n; k++)
      for (int c = 0; c < 3; c++) begin
        n_vec++;
        if (s_wr0 + 3 * k + c >= wr_addr_q.size() || wr_addr_q[s_wr0 + 3 * k + c] !== model_addr(n, k, c) ||
            wr_data_q[s_wr0 + 3 * k + c] !== model_data(k, c)) begin
          n_err++; $display("FAIL boundary_write k=%0d c=%0d: got %0h/%0h, expected %0h/%0h", k, c,
                            wr_addr_q[s_wr0 + 3 * k + c], wr_data_q[s_wr0 + 3 * k + c], model_addr(n, k, c), model_data(k, c));
        end
      end
  endtask

  task automatic test_zero_dim;
    int w0;
    w0 = wr_addr_q.size();
    iCol_Max = '0; iRow_Max = DW'(5); start_load = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (oLoad_done !== 1'b1) begin n_err++; $display("FAIL zero_done_rise: got %b, expected 1", oLoad_done); end
    n_vec++; if (oPixel_ready !== 1'b0) begin n_err++; $display("FAIL zero_ready: got %b, expected 0", oPixel_ready); end
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (oLoad_done !== 1'b1) begin n_err++; $display("FAIL zero_done_hold: got %b, expected 1", oLoad_done); end
    start_load = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (oLoad_done !== 1'b0) begin n_err++; $display("FAIL zero_done_fall: got %b, expected 0", oLoad_done); end
    @(posedge clk); #1;
    n_vec++; if (oPixel_ready !== 1'b0 || oLoad_done !== 1'b0) begin n_err++; $display("FAIL zero_idle: got ready=%b done=%b, expected 0/0", oPixel_ready, oLoad_done); end
    n_vec++; if (wr_addr_q.size() != w0) begin n_err++; $display("FAIL zero_writes: got %0d, expected 0", wr_addr_q.size() - w0); end
  endtask

  task automatic test_reset_mid_write;
    int k, cyc;
    bit hs, found, to;
    for (int i = 0; i < 32; i++) begin pr[i] = 8'($urandom); pg[i] = 8'($urandom); pb[i] = 8'($urandom); end
    iCol_Max = DW'(4); iRow_Max = DW'(4); start_load = 1'b1;
    @(posedge clk); #1;
    start_load = 1'b0;
    k = 0; cyc = 0; found = 1'b0;
    while (!found && cyc < 300) begin
      iPixel_valid = 1'b1; iPixel_R = pr[k]; iPixel_G = pg[k]; iPixel_B = pb[k];
      hs = oPixel_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) k++;
      if (k == 4 && !oSRAM_WE_N) found = 1'b1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL rst_strobe_timeout: strobe of pixel 3 not seen, expected within 300 cycles"); end
    #2 i_rst = 1'b1;
    iPixel_valid = 1'b0;
    #1;
    n_vec++; if (oSRAM_WE_N !== 1'b1) begin n_err++; $display("FAIL rst_async_we_n: got %b, expected 1", oSRAM_WE_N); end
    n_vec++; if (sram_dq !== 16'hFFFF) begin n_err++; $display("FAIL rst_async_data_z: got %0h, expected released bus", sram_dq); end
    @(posedge clk); #1;
    n_vec++; if (oPixel_ready !== 1'b0 || oSRAM_ADDR !== '0 || oLoad_done !== 1'b0) begin
      n_err++; $display("FAIL rst_state: got ready=%b addr=%0h done=%b, expected 0/0/0", oPixel_ready, oSRAM_ADDR, oLoad_done);
    end
    i_rst = 1'b0;
    @(posedge clk); #1;
    do_load(2, 2, 1'b0, to);
    n_vec++; if (to) begin n_err++; $display("FAIL reload_timeout: done not seen, expected done"); end
    n_vec++; if (wr_addr_q.size() <= s_wr0 || wr_addr_q[s_wr0] !== '0) begin n_err++; $display("FAIL reload_first_addr: got %0h, expected 0", wr_addr_q[s_wr0]); end
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < 3; c++) begin
        n_vec++;
        if (s_wr0 + 3 * i + c >= wr_addr_q.size() || wr_addr_q[s_wr0 + 3 * i + c] !== model_addr(4, i, c) ||
            wr_data_q[s_wr0 + 3 * i + c] !== model_data(i, c)) begin
          n_err++; $display("FAIL reload_write k=%0d c=%0d: got %0h/%0h, expected %0h/%0h", i, c,
                            wr_addr_q[s_wr0 + 3 * i + c], wr_data_q[s_wr0 + 3 * i + c], model_addr(4, i, c), model_data(i, c));
        end
      end
  endtask

  initial begin
    test_reset();
    test_held_5x5();
    test_gapped_5x5();
    test_photo_boundary();
    test_zero_dim();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_pixel_loader.md
# sram_pixel_loader

Upstream stage of `color_transform`. Accepts an RGB pixel stream for two photos (source, then target) and writes them into external SRAM in the planar layout `color_transform` reads: one 16-bit word per channel sample. Raises a done level that the top level uses as `start_transform`. It owns the SRAM bus only while loading; `color_transform` owns it afterwards.

## Interface
- `ADDR_W`, default 20: SRAM address width.
- `DIM_W`, default 10: width of the column and row count inputs.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `i_rst`  in  1  reset, asynchronous and active-high.
- `start_load`  in  1  level; a high level in IDLE begins a load.
- `iCol_Max`  in  DIM_W  columns per photo; sampled on leaving IDLE.
- `iRow_Max`  in  DIM_W  rows per photo; sampled on leaving IDLE.
- `iPixel_valid`  in  1  stream pixel valid.
- `iPixel_R`, `iPixel_G`, `iPixel_B`  in  8 each  pixel channels.
- `oPixel_ready`  out  1  pixel accepted when valid and ready are both high at a clock edge.
- `oSRAM_ADDR`  out  ADDR_W  SRAM address.
- `oSRAM_DATA`  out  16  tri-state; drives the shared DQ wire only in write states, Z otherwise.
- `oSRAM_WE_N`  out  1  write enable, active low.
- `oSRAM_OE_N`  out  1  output enable, active low; held 1, since this block never reads.
- `oLoad_done`  out  1  high in DONE.

## Operation
- N = iCol_Max*iRow_Max, computed once on leaving IDLE, width 2*DIM_W and truncated to ADDR_W.
- Address of channel c (R=0, G=1, B=2) of pixel p (raster order) in photo f (0 = source, 1 = target) is (f*3 + c)*N + p.
  - Generate it with a running plane-base adder (add N per channel step). No multiplier in the write path.
- Data word is {8'h00, channel}.
- FSM states:
  - IDLE: if start_load is high, go to WAIT_PIX, or to DONE if N == 0.
  - WAIT_PIX: oPixel_ready = 1. On handshake, latch R/G/B and go to WR_SETUP with c = 0.
  - WR_SETUP: drive address and data; WE_N = 1. Next state is WR_STROBE.
  - WR_STROBE: same address and data; WE_N = 0. After it:
    - if c < 2: c++ and return to WR_SETUP;
    - else if the pixel is not the last of photo 1: advance p (wrapping to 0 and incrementing f at N-1) and go to WAIT_PIX;
    - else go to DONE.
  - DONE: oLoad_done = 1. Stay until start_load is low, then go to IDLE.
- oPixel_ready is low in every state except WAIT_PIX. Pixels offered at any other time are held off, not dropped.
- start_load deasserted mid-load is ignored; the load runs to completion.
- Counters p, c, f and the plane base all clear on entry to WAIT_PIX from IDLE.

## Timing
- Reset values: oPixel_ready = 0, oSRAM_ADDR = 0, oSRAM_DATA = Z, oSRAM_WE_N = 1, oSRAM_OE_N = 1, oLoad_done = 0, state = IDLE.
- Reset asserted mid-write forces WE_N to 1 immediately (asynchronously) and aborts the load. The partial SRAM contents are don't-care.
- IDLE with start_load high -> WAIT_PIX on the next edge, with oPixel_ready high that cycle.
- Per pixel: 1 handshake cycle + 3 × (SETUP + STROBE) = 7 cycles minimum. Throughput is 1 pixel per 7 cycles.
- In each channel write, address and data are stable for one cycle before WE_N falls and throughout the WE_N-low cycle.
- oLoad_done rises on the edge after the final WR_STROBE, i.e. 6 cycles after the last handshake.
- After DONE, the SRAM bus is released: data Z, WE_N = 1.

## Structure
- Shared package `sram_pkg`:
  - ADDR_W;
  - the 16-bit data width;
  - the state enum `load_state_t` {IDLE, WAIT_PIX, WR_SETUP, WR_STROBE, DONE};
  - channel index constants CH_R, CH_G, CH_B.
- One sub-module, `sram_write_port`. It takes a request, address and data, and sequences SETUP/STROBE, owning WE_N and the DQ tri-state. It returns a one-cycle `wr_done`.

## Test plan
- 5×5 (N = 25), pixel k = (k, k+1, k+2) with valid held high.
  - Required: 150 writes.
  - Photo 0 pixel 0: addresses 0, 25, 50 with data 0000, 0001, 0002.
  - Photo 1 pixel 0: addresses 75, 100, 125.
  - Last write: address 149.
  - oLoad_done rises 6 cycles after the 50th handshake.
- Every write cycle: WE_N low only with address and data unchanged from the previous cycle. No handshake while ready is low. Pixel count is exactly 50.
- Randomly gapped iPixel_valid: same SRAM contents as the previous scenario. Ready never high outside WAIT_PIX.
- iCol_Max = 0: IDLE -> DONE with no writes; oLoad_done = 1 until start_load goes low, then IDLE.
- i_rst pulsed during the WR_STROBE of pixel 3: WE_N = 1 and data = Z without waiting for an edge. A new start_load then reloads from address 0.
- Photo boundary with a 3×2 array (N = 6): the 7th pixel writes 18, 24, 30 (f = 1, p = 0).
